// File: rtl/debug_unit_pkg.sv
// Shared constants and state encoding for the pipeline debug unit.
package debug_unit_pkg;

    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_RST  = 8'h72;
    localparam logic [7:0] HDR      = 8'hA5;

    localparam int FRAME_BYTES = 29;
    localparam int N_WORDS     = 7;
    localparam int IDX_W       = 5;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        CAPTURE,
        SEND,
        WAIT_TX,
        HALTED
    } state_t;

endpackage

// File: rtl/debug_frame_mux.sv
// Selects one byte of the outgoing snapshot frame: header first, then the
// snapshot words little-endian.
module debug_frame_mux
    import debug_unit_pkg::*;
#(
    parameter int B = 32
) (
    input  logic [N_WORDS-1:0][B-1:0] words,
    input  logic [IDX_W-1:0]          byte_idx,
    output logic [7:0]                tx_byte
);

    logic [IDX_W-1:0] k;

    always_comb begin
        k       = byte_idx - 5'd1;
        tx_byte = 8'h00;
        if (byte_idx == 5'd0) begin
            tx_byte = HDR;
        end else if (byte_idx < 5'(FRAME_BYTES)) begin
            tx_byte = words[k[4:2]][{k[1:0], 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Run-control and snapshot streaming for the MIPS pipeline: UART commands in,
// pipeline enable/soft reset out, 29-byte state frames to the UART transmitter.
//
// state   | meaning
// IDLE    | pipeline frozen, waiting for a command byte
// RUN     | pipeline free-running until the halt word reaches IF/ID
// STEP    | single enabled pipeline cycle
// CAPTURE | latch the seven snapshot words
// SEND    | issue tx_start for the current frame byte
// WAIT_TX | wait for the transmitter to finish that byte
// HALTED  | halt word held; only the reset command is accepted
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int            B          = 32,
    parameter int            W          = 5,
    parameter logic [B-1:0]  HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   rx_data,
    input  logic         rx_done,
    input  logic         tx_done,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic [B-1:0] pc_IF,
    input  logic [B-1:0] instruction_IF_ID,
    input  logic [B-1:0] alu_result_EX,
    input  logic [B-1:0] alu_result_EX_MEM,
    input  logic [B-1:0] mux_wb_data_WB,
    input  logic [W-1:0] reg_dest_addr_MEM_WB,
    output logic         pipe_en,
    output logic         pipe_reset,
    output logic         halted
);

    state_t                   state;
    logic [31:0]              cycle_cnt;
    logic [31:0]              cnt_next;
    logic [N_WORDS-1:0][B-1:0] snap;
    logic [IDX_W-1:0]         byte_idx;
    logic [7:0]               frame_byte;
    logic                     at_halt;
    logic                     rst_cmd;

    assign at_halt = (instruction_IF_ID == HALT_INSTR);
    assign rst_cmd = rx_done && (rx_data == CMD_RST) && (state == IDLE || state == HALTED);

    // RUN drops the enable in the very cycle the halt word appears, so the
    // pipeline never advances past it.
    always_comb begin
        pipe_en = 1'b0;
        if (state == STEP) begin
            pipe_en = 1'b1;
        end else if (state == RUN && !at_halt) begin
            pipe_en = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cycle_cnt;
        if (rst_cmd) begin
            cnt_next = '0;
        end else if (pipe_en) begin
            cnt_next = cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cnt_next;
        end
    end

    debug_frame_mux #(.B(B)) u_frame_mux (
        .words    (snap),
        .byte_idx (byte_idx),
        .tx_byte  (frame_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pipe_reset <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            halted     <= 1'b0;
            snap       <= '0;
            byte_idx   <= '0;
        end else begin
            pipe_reset <= 1'b0;
            tx_start   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_done) begin
                        if (rx_data == CMD_CONT) begin
                            state <= RUN;
                        end else if (rx_data == CMD_STEP) begin
                            state <= STEP;
                        end else if (rx_data == CMD_RST) begin
                            pipe_reset <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (at_halt) begin
                        state <= CAPTURE;
                    end
                end
                STEP: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    snap[0]  <= pc_IF;
                    snap[1]  <= instruction_IF_ID;
                    snap[2]  <= alu_result_EX;
                    snap[3]  <= alu_result_EX_MEM;
                    snap[4]  <= mux_wb_data_WB;
                    snap[5]  <= {{(B-W){1'b0}}, reg_dest_addr_MEM_WB};
                    snap[6]  <= B'(cycle_cnt);
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: begin
                    tx_start <= 1'b1;
                    tx_data  <= frame_byte;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    // Returning through SEND guarantees an idle cycle between bytes.
                    if (tx_done) begin
                        byte_idx <= byte_idx + 5'd1;
                        if (byte_idx == 5'(FRAME_BYTES - 1)) begin
                            if (at_halt) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                HALTED: begin
                    if (rx_done && rx_data == CMD_RST) begin
                        pipe_reset <= 1'b1;
                        halted     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: a simple transmitter model collects frame
// bytes while the main sequence issues commands and checks results.
module tb_debug_unit;
    import debug_unit_pkg::*;

    localparam logic [31:0] PC0   = 32'h0000_1004;
    localparam logic [31:0] INS0  = 32'h2001_0005;
    localparam logic [31:0] EX0   = 32'hDEAD_BEEF;
    localparam logic [31:0] MEM0  = 32'h1234_5678;
    localparam logic [31:0] WB0   = 32'hCAFE_0001;
    localparam logic [4:0]  RD0   = 5'd17;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [31:0] pc_IF = PC0;
    logic [31:0] instruction_IF_ID = INS0;
    logic [31:0] alu_result_EX = EX0;
    logic [31:0] alu_result_EX_MEM = MEM0;
    logic [31:0] mux_wb_data_WB = WB0;
    logic [4:0]  reg_dest_addr_MEM_WB = RD0;
    logic        pipe_en;
    logic        pipe_reset;
    logic        halted;

    int checks = 0;
    int errors = 0;
    int pe_cnt = 0;
    int pr_cnt = 0;
    int ts_cnt = 0;
    int done_cnt = 0;
    logic [7:0]  rxq[$];
    logic [31:0] exp_w [7];

    debug_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .rx_data              (rx_data),
        .rx_done              (rx_done),
        .tx_done              (tx_done),
        .tx_start             (tx_start),
        .tx_data              (tx_data),
        .pc_IF                (pc_IF),
        .instruction_IF_ID    (instruction_IF_ID),
        .alu_result_EX        (alu_result_EX),
        .alu_result_EX_MEM    (alu_result_EX_MEM),
        .mux_wb_data_WB       (mux_wb_data_WB),
        .reg_dest_addr_MEM_WB (reg_dest_addr_MEM_WB),
        .pipe_en              (pipe_en),
        .pipe_reset           (pipe_reset),
        .halted               (halted)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        if (pipe_en)    pe_cnt++;
        if (pipe_reset) pr_cnt++;
        if (tx_start)   ts_cnt++;
    end

    // Transmitter model: byte takes a few cycles, then a one-cycle tx_done.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                rxq.push_back(tx_data);
                repeat (2) @(negedge clk);
                tx_done = 1'b1;
                done_cnt++;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic wait_frame(input int fb);
        int n;
        n = 0;
        while (rxq.size() < fb + FRAME_BYTES && n < 3000) begin
            tick();
            n++;
        end
        check("frame_timeout", 32'(rxq.size() >= fb + FRAME_BYTES), 32'd1);
        repeat (6) tick();
    endtask

    task automatic set_words(input logic [31:0] w1, input logic [31:0] w6);
        exp_w[0] = PC0;
        exp_w[1] = w1;
        exp_w[2] = EX0;
        exp_w[3] = MEM0;
        exp_w[4] = WB0;
        exp_w[5] = 32'(RD0);
        exp_w[6] = w6;
    endtask

    task automatic check_frame(input string tag, input int fb);
        logic [31:0] w;
        logic [31:0] obs;
        logic [7:0]  e;
        check({tag, "_len"}, 32'(rxq.size() - fb), 32'(FRAME_BYTES));
        for (int i = 0; i < FRAME_BYTES; i++) begin
            if (i == 0) begin
                e = 8'hA5;
            end else begin
                w = exp_w[(i - 1) / 4];
                e = w[8 * ((i - 1) % 4) +: 8];
            end
            obs = (fb + i < rxq.size()) ? 32'(rxq[fb + i]) : 32'hDEAD_0000;
            check($sformatf("%s_b%0d", tag, i), obs, 32'(e));
        end
    endtask

    initial begin
        int pe0, pr0, ts0, fb, d0, n;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_pipe_en", 32'(pipe_en), 32'd0);
        check("rst_pipe_reset", 32'(pipe_reset), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        tick();

        // Single step from reset
        pe0 = pe_cnt; ts0 = ts_cnt; fb = rxq.size();
        send_cmd(CMD_STEP);
        check("step_pipe_en", 32'(pipe_en), 32'd1);
        tick();
        check("step_pipe_en_off", 32'(pipe_en), 32'd0);
        wait_frame(fb);
        check("step_pe_cycles", 32'(pe_cnt - pe0), 32'd1);
        check("step_tx_starts", 32'(ts_cnt - ts0), 32'd29);
        set_words(INS0, 32'd1);
        check_frame("step", fb);
        check("step_state", 32'(dut.state), 32'(IDLE));
        check("step_halted", 32'(halted), 32'd0);

        // Clear counter, then continuous run halting after 10 enabled cycles
        send_cmd(CMD_RST);
        check("rst_cmd_pulse", 32'(pipe_reset), 32'd1);
        tick();
        check("rst_cmd_pulse_end", 32'(pipe_reset), 32'd0);
        pe0 = pe_cnt; fb = rxq.size();
        send_cmd(CMD_CONT);
        repeat (10) tick();
        instruction_IF_ID = HALTW;
        wait_frame(fb);
        check("cont_pe_cycles", 32'(pe_cnt - pe0), 32'd10);
        set_words(HALTW, 32'h0000_000A);
        check_frame("cont", fb);
        check("cont_halted", 32'(halted), 32'd1);
        check("cont_state", 32'(dut.state), 32'(HALTED));

        // In HALTED: step ignored, reset accepted
        pe0 = pe_cnt; ts0 = ts_cnt;
        send_cmd(CMD_STEP);
        repeat (5) tick();
        check("halt_step_ignored_halted", 32'(halted), 32'd1);
        check("halt_step_ignored_pe", 32'(pe_cnt - pe0), 32'd0);
        check("halt_step_ignored_tx", 32'(ts_cnt - ts0), 32'd0);
        pr0 = pr_cnt;
        send_cmd(CMD_RST);
        check("halt_rst_pulse", 32'(pipe_reset), 32'd1);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_state", 32'(dut.state), 32'(IDLE));
        tick();
        check("halt_rst_pulse_end", 32'(pipe_reset), 32'd0);
        check("halt_rst_pulse_count", 32'(pr_cnt - pr0), 32'd1);
        instruction_IF_ID = INS0;
        tick();
        fb = rxq.size();
        send_cmd(CMD_STEP);
        wait_frame(fb);
        set_words(INS0, 32'd1);
        check_frame("after_rst", fb);

        // Step command and input changes while a frame is streaming
        pe0 = pe_cnt; ts0 = ts_cnt; fb = rxq.size();
        send_cmd(CMD_STEP);
        n = 0;
        while (rxq.size() < fb + 5 && n < 1000) begin
            tick();
            n++;
        end
        pc_IF = 32'h5555_5555;
        instruction_IF_ID = 32'h0000_0000;
        alu_result_EX = 32'h1111_1111;
        alu_result_EX_MEM = 32'h2222_2222;
        mux_wb_data_WB = 32'h3333_3333;
        reg_dest_addr_MEM_WB = 5'd3;
        send_cmd(CMD_STEP);
        wait_frame(fb);
        check("busy_pe_cycles", 32'(pe_cnt - pe0), 32'd1);
        check("busy_tx_starts", 32'(ts_cnt - ts0), 32'd29);
        set_words(INS0, 32'd2);
        check_frame("busy", fb);
        check("busy_state", 32'(dut.state), 32'(IDLE));
        pc_IF = PC0;
        instruction_IF_ID = INS0;
        alu_result_EX = EX0;
        alu_result_EX_MEM = MEM0;
        mux_wb_data_WB = WB0;
        reg_dest_addr_MEM_WB = RD0;

        // Counter wrap
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        repeat (2) tick();
        release dut.cycle_cnt;
        tick();
        fb = rxq.size();
        send_cmd(CMD_STEP);
        wait_frame(fb);
        set_words(INS0, 32'h0000_0000);
        check_frame("wrap", fb);

        // Reset mid-frame after byte 10 completes
        ts0 = ts_cnt; d0 = done_cnt;
        send_cmd(CMD_STEP);
        n = 0;
        while (done_cnt < d0 + 11 && n < 1000) begin
            tick();
            n++;
        end
        check("mid_timeout", 32'(done_cnt >= d0 + 11), 32'd1);
        reset = 1'b1;
        tick();
        check("mid_state", 32'(dut.state), 32'(IDLE));
        check("mid_tx_start", 32'(tx_start), 32'd0);
        check("mid_tx_data", 32'(tx_data), 32'd0);
        check("mid_pipe_en", 32'(pipe_en), 32'd0);
        check("mid_pipe_reset", 32'(pipe_reset), 32'd0);
        check("mid_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        repeat (10) tick();
        check("mid_no_reissue", 32'(ts_cnt - ts0), 32'd11);
        ts0 = ts_cnt; fb = rxq.size();
        send_cmd(CMD_STEP);
        wait_frame(fb);
        check("fresh_tx_starts", 32'(ts_cnt - ts0), 32'd29);
        set_words(INS0, 32'd1);
        check_frame("fresh", fb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Run-control and observation stage sitting directly downstream of the five-stage MIPS pipeline top. It consumes the pipeline's test/observation outputs and drives the pipeline clock-enable and a soft reset. Command bytes arrive from a UART receiver. Snapshot frames of pipeline state are streamed byte-by-byte to a UART transmitter over a start/done handshake. It supports continuous run-to-halt and single-step modes.

Parameters:
B, 32, datapath/PC width of observed words
W, 5, register-address width
HALT_INSTR, 32'hFFFF_FFFF, instruction word in IF/ID that stops continuous run
CMD_CONT, 8'h63 ('c'), run continuously until halt
CMD_STEP, 8'h73 ('s'), advance exactly one pipeline cycle
CMD_RST, 8'h72 ('r'), pulse pipeline reset, clear counter
HDR, 8'hA5, first byte of every frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received command byte, valid when rx_done=1
rx_done  in  1  one-cycle pulse: byte received
tx_done  in  1  one-cycle pulse: transmitter finished current byte
tx_start  out  1  one-cycle pulse: load tx_data into transmitter
tx_data  out  8  byte to transmit, held stable from tx_start until tx_done
pc_IF  in  B  incremented PC in IF
instruction_IF_ID  in  B  instruction in IF/ID latch
alu_result_EX  in  B  EX ALU result
alu_result_EX_MEM  in  B  EX/MEM ALU result
mux_wb_data_WB  in  B  write-back data
reg_dest_addr_MEM_WB  in  W  write-back destination register
pipe_en  out  1  pipeline register/PC update enable
pipe_reset  out  1  one-cycle soft reset to pipeline
halted  out  1  high while the halt instruction is held

Behaviour:
- Reset values: state IDLE; pipe_en=0, pipe_reset=0, tx_start=0, tx_data=0, halted=0; cycle_cnt=0; snapshot regs=0; byte_idx=0.
- States:
  - IDLE
  - RUN
  - STEP
  - CAPTURE
  - SEND
  - WAIT_TX
  - HALTED
- pipe_en is combinational: 1 in STEP; 1 in RUN iff instruction_IF_ID != HALT_INSTR; else 0.
- cycle_cnt: 32-bit, increments on every edge with pipe_en=1; wraps FFFF_FFFF->0; cleared by reset or pipe_reset.
- IDLE transitions:
  - rx_done with CMD_CONT -> RUN.
  - rx_done with CMD_STEP -> STEP.
  - rx_done with CMD_RST -> pipe_reset=1 next cycle for exactly one cycle, cycle_cnt cleared, stay IDLE.
  - Other bytes are ignored.
- RUN: when instruction_IF_ID == HALT_INSTR -> CAPTURE. No extra advance: pipe_en is already 0 that cycle.
- STEP: exactly one cycle -> CAPTURE.
- CAPTURE: one cycle. Latches words 0..6, then -> SEND with byte_idx=0.
  - word0 pc_IF
  - word1 instruction_IF_ID
  - word2 alu_result_EX
  - word3 alu_result_EX_MEM
  - word4 mux_wb_data_WB
  - word5 zero-extended reg_dest_addr_MEM_WB
  - word6 cycle_cnt
- Frame: 29 bytes. Byte 0 = HDR; bytes 1..28 = words 0..6, each little-endian (byte 1 = word0[7:0]).
- SEND: tx_start=1 for one cycle with tx_data=frame[byte_idx] -> WAIT_TX.
- WAIT_TX: on tx_done, byte_idx++. If byte_idx was 28 -> HALTED if instruction_IF_ID==HALT_INSTR, else IDLE. Otherwise -> SEND.
- Inter-byte gap: at least one idle cycle between tx_done and the next tx_start.
- HALTED: halted=1. Only CMD_RST accepted: pipe_reset pulse, cycle_cnt cleared -> IDLE. All other bytes ignored.
- rx_done outside IDLE/HALTED is dropped, not queued. rx_done coincident with tx_done: the tx path proceeds and the rx byte is dropped.
- Snapshot stays stable for the entire frame, whatever the pipeline inputs do.
- Reset mid-frame: return to IDLE immediately. tx_start is not reissued; the partial frame is abandoned.
- tx_done received outside WAIT_TX is ignored.

Decomposition:
- Shared package holds:
  - command byte constants and HDR
  - FRAME_BYTES=29 and N_WORDS=7
  - state enum
- Natural sub-module: debug_frame_mux. A combinational byte selector over the snapshot words: byte_idx -> tx_data. It is instantiated once.

Test Plan:
- Reset, then 's' -> one cycle of pipe_en=1, cycle_cnt=1. Frame starts A5; word6 bytes 01 00 00 00; 29 tx_start pulses; returns to IDLE.
- 'c' with HALT_INSTR presented 10 cycles later -> pipe_en high for exactly 10 cycles. Frame word6=0000000A, word1 bytes FF FF FF FF; halted=1.
- In HALTED send 's' then 'r' -> 's' ignored. 'r' gives a single-cycle pipe_reset, halted=0, and the next 's' frame reports word6=1.
- 's' issued while a frame is streaming -> no extra pipe_en pulse; frame byte order unchanged; state returns to IDLE.
- cycle_cnt forced to FFFF_FFFF then 's' -> word6 reported as 00000000.
- Assert reset after byte 10's tx_done -> next cycle IDLE with all outputs zero; a fresh 's' produces a complete 29-byte frame.
